// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle integer ops plus iterative shift-add multiply and
// restoring divide. One request is in flight at a time; DONE pulses once per request.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       dbg_state
);
    // Handshake: START is the request valid and !BUSY is ready; a request is taken on
    // any rising edge with START=1 and BUSY=0, and DONE pulses once when RESULT is valid.
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b10000, OP_SLL  = 5'b00001,
                           OP_SRL  = 5'b00101, OP_SRA  = 5'b10101, OP_SLT  = 5'b00010,
                           OP_SLTU = 5'b00011, OP_XOR  = 5'b00100, OP_OR   = 5'b00110,
                           OP_AND  = 5'b00111, OP_MUL  = 5'b01000, OP_MULH = 5'b01001,
                           OP_MULHSU = 5'b01010, OP_DIV = 5'b01100, OP_REM = 5'b01110;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  acc_q, acc_d;   // product high half / partial remainder
    logic [WIDTH-1:0]  lo_q, lo_d;     // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]  opd_q, opd_d;   // multiplicand / divisor magnitude
    logic              neg_q, neg_d;   // negate the unsigned result at the end
    logic [4:0]        op_q, op_d;

    logic [WIDTH-1:0]  alu_res, mag_a, mag_b;
    logic [SW-1:0]     shamt;
    logic              is_mul, is_div, a_sgn, b_sgn, ovf, last;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]  mul_hi_n, mul_lo_n, rem_n, quo_n, quo_s, rem_s;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic              div_ge;

    assign shamt  = DATA2[SW-1:0];
    assign is_mul = (SELECT[4:2] == 3'b010);
    assign is_div = (SELECT[4:2] == 3'b011);
    assign a_sgn  = (SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
                    (SELECT == OP_DIV)  || (SELECT == OP_REM);
    assign b_sgn  = (SELECT == OP_MULH) || (SELECT == OP_DIV) || (SELECT == OP_REM);
    assign mag_a  = (a_sgn && DATA1[WIDTH-1]) ? -DATA1 : DATA1;
    assign mag_b  = (b_sgn && DATA2[WIDTH-1]) ? -DATA2 : DATA2;
    assign ovf    = (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);

    always_comb begin
        alu_res = '0;
        case (SELECT)
            OP_ADD:  alu_res = DATA1 + DATA2;
            OP_SUB:  alu_res = DATA1 - DATA2;
            OP_SLL:  alu_res = DATA1 << shamt;
            OP_SRL:  alu_res = DATA1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(DATA1) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(DATA1) < $signed(DATA2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, DATA1 < DATA2};
            OP_XOR:  alu_res = DATA1 ^ DATA2;
            OP_OR:   alu_res = DATA1 | DATA2;
            OP_AND:  alu_res = DATA1 & DATA2;
            default: alu_res = '0;
        endcase
    end

    // One unsigned iteration of each datapath; signs are reapplied on the last step.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign mul_hi_n  = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign prod      = {mul_hi_n, mul_lo_n};
    assign prod_s    = neg_q ? -prod : prod;
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opd_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign rem_n     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_n     = {lo_q[WIDTH-2:0], div_ge};
    assign quo_s     = neg_q ? -quo_n : quo_n;
    assign rem_s     = neg_q ? -rem_n : rem_n;
    assign last      = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        neg_d    = neg_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d  = SELECT;
                    cnt_d = '0;
                    if (is_mul) begin
                        state_d = S_MUL;
                        acc_d   = '0;
                        lo_d    = mag_b;
                        opd_d   = mag_a;
                        neg_d   = (a_sgn & DATA1[WIDTH-1]) ^ (b_sgn & DATA2[WIDTH-1]);
                    end else if (is_div && DATA2 == '0) begin
                        result_d = SELECT[1] ? DATA1 : '1;
                        done_d   = 1'b1;
                    end else if (is_div && !SELECT[0] && ovf) begin
                        result_d = SELECT[1] ? '0 : DATA1;
                        done_d   = 1'b1;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        acc_d   = '0;
                        lo_d    = mag_a;
                        opd_d   = mag_b;
                        neg_d   = SELECT[0] ? 1'b0 :
                                  (SELECT[1] ? DATA1[WIDTH-1] : DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = S_IDLE;
                    result_d = (op_q == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = rem_n;
                lo_d  = quo_n;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = S_IDLE;
                    result_d = op_q[1] ? rem_s : quo_s;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
        end
    end

    assign RESULT    = result_q;
    assign DONE      = done_q;
    assign BUSY      = (state_q != S_IDLE);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, hand-written corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    localparam logic [4:0] C_ADD = 5'b00000, C_SUB = 5'b10000, C_SLL = 5'b00001,
                           C_SRL = 5'b00101, C_SRA = 5'b10101, C_SLT = 5'b00010,
                           C_SLTU = 5'b00011, C_XOR = 5'b00100, C_OR = 5'b00110,
                           C_AND = 5'b00111, C_MUL = 5'b01000, C_MULH = 5'b01001,
                           C_MULHSU = 5'b01010, C_MULHU = 5'b01011, C_DIV = 5'b01100,
                           C_DIVU = 5'b01101, C_REM = 5'b01110, C_REMU = 5'b01111;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         START = 1'b0;
    logic [4:0]   SELECT = '0;
    logic [W-1:0] DATA1 = '0;
    logic [W-1:0] DATA2 = '0;
    logic [W-1:0] RESULT;
    logic         BUSY;
    logic         DONE;
    logic [1:0]   dbg_state;

    seq_alu #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .BUSY(BUSY),
        .DONE(DONE), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res = '0;
    logic [31:0] exp_q[$];
    vec_t        vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operand values.
    function automatic logic [31:0] ref_res(input logic [4:0] s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [4:0]  sh = b[4:0];
        logic [63:0] p;
        case (s)
            C_ADD:    return a + b;
            C_SUB:    return a - b;
            C_SLL:    return a << sh;
            C_SRL:    return a >> sh;
            C_SRA:    begin p = 64'(sa >>> sh); return p[31:0]; end
            C_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            C_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
            C_XOR:    return a ^ b;
            C_OR:     return a | b;
            C_AND:    return a & b;
            C_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            C_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            C_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            C_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            C_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            C_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            C_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
            C_REMU:   begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] s, input logic [31:0] a,
                                   input logic [31:0] b);
        if (s == C_MUL || s == C_MULH || s == C_MULHSU || s == C_MULHU) return W;
        if (s == C_DIV || s == C_DIVU || s == C_REM || s == C_REMU) begin
            if (b == 0) return 0;
            if ((s == C_DIV || s == C_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return W;
        end
        return 0;
    endfunction

    // Issues one request at the current falling edge, waits for DONE and checks it.
    // lat counts edges after the accepting edge; poke >= 0 re-pulses START mid-op.
    task automatic do_op(input string nm, input logic [4:0] s, input logic [31:0] a,
                         input logic [31:0] b, input int poke);
        int          lat;
        int          busy_n;
        logic        held;
        logic [31:0] exp_res;
        exp_q.push_back(ref_res(s, a, b));
        START = 1'b1; SELECT = s; DATA1 = a; DATA2 = b;
        @(negedge CLK);
        START = 1'b0; SELECT = 5'($urandom); DATA1 = $urandom; DATA2 = $urandom;
        lat = 0; busy_n = 0; held = 1'b1;
        while (DONE !== 1'b1 && lat < 100) begin
            if (RESULT !== last_res) held = 1'b0;
            if (BUSY === 1'b1) busy_n++;
            START = (lat == poke);
            @(negedge CLK);
            START = 1'b0;
            lat++;
        end
        exp_res = exp_q.pop_front();
        chk($sformatf("%s result", nm), 64'(RESULT), 64'(exp_res));
        chk($sformatf("%s latency", nm), 64'(lat), 64'(ref_lat(s, a, b)));
        chk($sformatf("%s busy_cycles", nm), 64'(busy_n), 64'(ref_lat(s, a, b)));
        chk($sformatf("%s busy_at_done", nm), 64'(BUSY), 64'd0);
        chk($sformatf("%s result_held", nm), 64'(held), 64'd1);
        last_res = exp_res;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ops[21];
        logic [31:0] specials[6];
        logic [31:0] ra, rb;
        logic        saw_done;

        vecs.push_back('{C_ADD,   32'd5,          32'd10,         32'd15,         0});
        vecs.push_back('{C_SUB,   32'd15,         32'd10,         32'd5,          0});
        vecs.push_back('{C_SLT,   32'd6,          32'hFFFF_FFFE,  32'd0,          0});
        vecs.push_back('{C_SLTU,  32'd6,          32'hFFFF_FFFE,  32'd1,          0});
        vecs.push_back('{C_SRA,   32'h8000_0000,  32'd36,         32'hF800_0000,  0});
        vecs.push_back('{C_SRL,   32'h8000_0000,  32'd31,         32'd1,          0});
        vecs.push_back('{C_SLL,   32'd1,          32'd33,         32'd2,          0});
        vecs.push_back('{C_XOR,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  0});
        vecs.push_back('{C_OR,    32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  0});
        vecs.push_back('{C_AND,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  0});
        vecs.push_back('{5'b11111, 32'd7,         32'd9,          32'd0,          0});
        vecs.push_back('{C_MULH,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  W});
        vecs.push_back('{C_MUL,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA,  W});
        vecs.push_back('{C_MULHSU, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF,  W});
        vecs.push_back('{C_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  W});
        vecs.push_back('{C_DIVU,  32'd100,        32'd7,          32'd14,         W});
        vecs.push_back('{C_REMU,  32'd100,        32'd7,          32'd2,          W});
        vecs.push_back('{C_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  W});
        vecs.push_back('{C_REM,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  W});
        vecs.push_back('{C_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0});
        vecs.push_back('{C_REM,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0});
        vecs.push_back('{C_DIVU,  32'd9,          32'd0,          32'hFFFF_FFFF,  0});
        vecs.push_back('{C_REMU,  32'd9,          32'd0,          32'd9,          0});

        // Reset state, with START held high during reset
        START = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        chk("reset RESULT", 64'(RESULT), 64'd0);
        chk("reset BUSY", 64'(BUSY), 64'd0);
        chk("reset DONE", 64'(DONE), 64'd0);
        chk("reset state", 64'(dbg_state), 64'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // Directed table, issued back-to-back (START in the DONE cycle)
        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("vec%0d table_vs_model", i),
                64'(ref_res(vecs[i].sel, vecs[i].a, vecs[i].b)), 64'(vecs[i].exp));
            chk($sformatf("vec%0d lat_vs_model", i),
                64'(ref_lat(vecs[i].sel, vecs[i].a, vecs[i].b)), 64'(vecs[i].lat));
            do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, -1);
        end
        @(negedge CLK);
        chk("done single pulse", 64'(DONE), 64'd0);
        chk("result held idle", 64'(RESULT), 64'(last_res));

        // START pulsed mid-divide must be ignored
        do_op("divu poked", C_DIVU, 32'd100, 32'd7, 5);
        @(negedge CLK);
        chk("poke no extra done", 64'(DONE), 64'd0);
        chk("poke state idle", 64'(dbg_state), 64'd0);

        // Reset in cycle 10 of a divide aborts it without a DONE pulse
        START = 1'b1; SELECT = C_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        chk("mid-div busy", 64'(BUSY), 64'd1);
        chk("mid-div state", 64'(dbg_state), 64'd2);
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort BUSY", 64'(BUSY), 64'd0);
        chk("abort DONE", 64'(DONE), 64'd0);
        chk("abort RESULT", 64'(RESULT), 64'd0);
        RESET = 1'b1;
        last_res = '0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE === 1'b1) saw_done = 1'b1;
        end
        chk("abort no done", 64'(saw_done), 64'd0);
        do_op("add after reset", C_ADD, 32'd1, 32'd1, -1);

        // Randomized ops against the reference model
        ops = '{C_ADD, C_SUB, C_SLL, C_SRL, C_SRA, C_SLT, C_SLTU, C_XOR, C_OR, C_AND,
                C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU,
                5'b10001, 5'b11111, 5'b10010};
        specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        for (int i = 0; i < 250; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            do_op($sformatf("rand%0d", i), ops[$urandom_range(0, 20)], ra, rb, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width (even, >= 8).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  reset; one clock, reset synchronous and active-low (RESET=0 clears state at rising CLK edge).
REQ-004 SHALL have port START  input  1  request; operands/SELECT captured at the edge where START=1 and BUSY=0.
REQ-005 SHALL have port SELECT  input  5  operation code.
REQ-006 SHALL have port DATA1  input  WIDTH  operand A / dividend / shift source.
REQ-007 SHALL have port DATA2  input  WIDTH  operand B / divisor / shift amount.
REQ-008 SHALL have port RESULT  output  WIDTH  registered result, held until next DONE.
REQ-009 SHALL have port BUSY  output  1  high while a multi-cycle op iterates.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse, RESULT valid.

Function
REQ-011 SELECT encoding SHALL be: 00000 ADD, 10000 SUB, 00001 SLL, 00101 SRL, 10101 SRA, 00010 SLT, 00011 SLTU, 00100 XOR, 00110 OR, 00111 AND, 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
REQ-012 Unlisted SELECT codes SHALL produce RESULT=0 with single-cycle latency.
REQ-013 States SHALL be IDLE, MUL, DIV; DONE is a registered output flag, not a state.
REQ-014 Single-cycle ops (ADD..AND, unlisted): START accepted at edge k -> RESULT updated and DONE=1 after edge k; state stays IDLE; BUSY stays 0.
REQ-015 Shifts SHALL use only DATA2[$clog2(WIDTH)-1:0]; SRA sign-fills; SLT signed compare, SLTU unsigned; results 1/0 zero-extended.
REQ-016 ADD/SUB SHALL wrap modulo 2^WIDTH; no flags.
REQ-017 MUL*: START at edge k -> IDLE->MUL, BUSY=1 after edge k; one shift-add iteration per edge; RESULT and DONE=1 after edge k+WIDTH, BUSY=0 at same time, state->IDLE.
REQ-018 MUL SHALL return low WIDTH bits of 2*WIDTH product; MULH high bits signed x signed; MULHSU signed DATA1 x unsigned DATA2; MULHU unsigned x unsigned.
REQ-019 DIV*: restoring/non-restoring, one quotient bit per edge; same timing as REQ-017 (DONE after edge k+WIDTH).
REQ-020 Signed DIV SHALL truncate toward zero; REM sign follows dividend.
REQ-021 Divisor==0 SHALL complete single-cycle (DONE after edge k, no DIV state): DIV/DIVU -> all ones, REM/REMU -> DATA1.
REQ-022 Signed overflow (DATA1=-2^(WIDTH-1), DATA2=-1) SHALL complete single-cycle: DIV -> DATA1, REM -> 0.
REQ-023 START while BUSY=1 SHALL be ignored; operands and SELECT SHALL not be re-sampled mid-operation.
REQ-024 START=1 in the cycle DONE=1 (BUSY=0) SHALL be accepted: back-to-back ops, no bubble.
REQ-025 DONE SHALL be high exactly one cycle per accepted request; RESULT SHALL not change except on the edge raising DONE (or reset).
REQ-026 Iteration counter SHALL be $clog2(WIDTH)+1 bits, cleared on acceptance; no wrap beyond WIDTH.

Reset
REQ-027 RESET=0 at an edge SHALL force state IDLE, RESULT=0, BUSY=0, DONE=0, counter=0, regardless of START.
REQ-028 RESET=0 mid-MUL/DIV SHALL abort with no DONE pulse; first START after RESET=1 SHALL be accepted normally.

Verification
REQ-029 ADD 5+10, then SUB 15-10 back-to-back -> RESULT=15 DONE 1 cycle later, then RESULT=5 next cycle; BUSY never 1.
REQ-030 SLT 6 vs 0xFFFFFFFE -> 0; SLTU same -> 1; SRA 0x80000000 by 36 -> 0xF8000000 (amount 4).
REQ-031 MULH 0xFFFFFFFE x 3 -> 0xFFFFFFFF; MUL same -> 0xFFFFFFFA; DONE exactly 32 cycles after START edge, BUSY high 32 cycles.
REQ-032 DIVU 100/7 -> 14, REMU -> 2 (32 cycles); DIV -7/2 -> -3, REM -> -1; START pulsed mid-op ignored.
REQ-033 DIV 0x80000000/-1 -> 0x80000000 and DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9, each DONE after 1 cycle.
REQ-034 RESET=0 at cycle 10 of DIVU -> BUSY/DONE/RESULT 0 next edge, no DONE pulse; subsequent ADD 1+1 -> 2.
